instr_fetch_issue: RTL

Front end of the LUMOS core. Fetches 16-bit instructions from instruction memory over a req/ack handshake and buffers them in a small FIFO. Splits each instruction into opcode and register/immediate fields and presents them to the opcode decoder through a valid/ready handshake. Handles taken branches by flushing the buffer and redirecting the fetch PC.

---
 rtl/instr_fetch_issue.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_issue.sv
// instr_fetch_issue: LUMOS front end.
// Fetches 16-bit instructions over a req/ack memory handshake into a small
// FIFO and presents the decoded head fields through a valid/ready handshake.
// A taken branch flushes the FIFO and redirects the fetch PC. If a request is
// still outstanding when the branch arrives, that request is drained and its
// data thrown away.
// Optional macro ISSUE_PERF_CNT_EN adds the saturating issued_count and
// flush_count outputs.
module instr_fetch_issue #(
  parameter int IW       = 16,
  parameter int AW       = 8,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  output logic          issue_valid,
  input  logic          issue_ready,
  output logic [2:0]    opcode,
  output logic [2:0]    rs,
  output logic [2:0]    rt,
  output logic [2:0]    rd,
  output logic [6:0]    imm,
  output logic [AW-1:0] issue_pc,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [15:0]   issued_count,
  output logic [15:0]   flush_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FULL,
    DRAIN
  } state_t;

  state_t          state;
  logic [AW-1:0]   fetch_pc;
  logic [AW-1:0]   pc_next_seq;

  logic [IW-1:0]   data_mem [DEPTH];
  logic [AW-1:0]   pc_mem   [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;

  logic            push;
  logic            pop;
  logic [IW-1:0]   head_instr;
  logic [AW-1:0]   head_pc;

  // A branch cancels both the push and the pop of its cycle.
  assign push        = (state == REQ) && imem_ack && !branch_taken;
  assign pop         = issue_valid && issue_ready && !branch_taken;
  assign issue_valid = (count != '0);
  assign pc_next_seq = fetch_pc + AW'(1);
  assign head_instr  = data_mem[rd_ptr];
  assign head_pc     = pc_mem[rd_ptr];

  // Occupancy after this edge, used to decide whether the FSM must stop fetching.
  always_comb begin
    count_next = count;
    if (branch_taken) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + CW'(1);
        2'b01:   count_next = count - CW'(1);
        default: count_next = count;
      endcase
    end
  end

  // Fetch FSM: owns the request lines and the fetch PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= AW'(RESET_PC);
      fetch_pc  <= AW'(RESET_PC);
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
          if (branch_taken) begin
            fetch_pc  <= branch_target;
            imem_addr <= branch_target;
          end else begin
            imem_addr <= fetch_pc;
          end
        end

        REQ: begin
          if (branch_taken) begin
            fetch_pc <= branch_target;
            if (imem_ack) begin
              state     <= REQ;
              imem_addr <= branch_target;
            end else begin
              state <= DRAIN;
            end
          end else if (imem_ack) begin
            fetch_pc  <= pc_next_seq;
            imem_addr <= pc_next_seq;
            if (count_next == CW'(DEPTH)) begin
              state    <= FULL;
              imem_req <= 1'b0;
            end
          end
        end

        FULL: begin
          if (branch_taken) begin
            fetch_pc  <= branch_target;
            imem_addr <= branch_target;
            imem_req  <= 1'b1;
            state     <= REQ;
          end else if (pop) begin
            imem_addr <= fetch_pc;
            imem_req  <= 1'b1;
            state     <= REQ;
          end
        end

        DRAIN: begin
          if (branch_taken) begin
            fetch_pc <= branch_target;
          end
          if (imem_ack) begin
            state     <= REQ;
            imem_addr <= branch_taken ? branch_target : fetch_pc;
          end
        end

        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; a branch empties the buffer outright.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (branch_taken) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_next;
    end
  end

  // FIFO storage holds each instruction together with its fetch address.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= fetch_pc;
    end
  end

  // Head field split; everything reads as zero while the FIFO is empty.
  always_comb begin
    opcode   = '0;
    rs       = '0;
    rt       = '0;
    rd       = '0;
    imm      = '0;
    issue_pc = '0;
    if (issue_valid) begin
      opcode   = head_instr[15:13];
      rs       = head_instr[12:10];
      rt       = head_instr[9:7];
      rd       = head_instr[6:4];
      imm      = head_instr[6:0];
      issue_pc = head_pc;
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  // Saturating event counters for issued instructions and branch flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      issued_count <= '0;
      flush_count  <= '0;
    end else begin
      if (pop && (issued_count != 16'hFFFF)) begin
        issued_count <= issued_count + 16'd1;
      end
      if (branch_taken && (flush_count != 16'hFFFF)) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end
`endif

endmodule
